mem2axi_bridge: RTL and testbench
=================================

// Module: mem2axi_bridge
// PURPOSE
//  Converts the core-side memory interface (cs/we/addr/byte/di -> do/busy/err) into single-beat AXI4 master transactions.
//  Lets a core port, cache-bypass path or DMA drive an slave port of the 4x4 AXI interconnect.
//  It is the initiator counterpart of the axi2mem responder bridge. One outstanding transaction at a time; no bursts.
// PARAMETERS
//  ID_WIDTH  10     width of AXI ID fields (matches interconnect slave-port ID width)
//  AXI_ID    0      constant ID driven on m_awid/m_arid; response IDs are ignored
// PORTS
//  clk            in   1         clock; all logic on rising edge
//  rst            in   1         asynchronous, active-high reset
//  s_cs           in   1         request strobe; held with payload stable while s_busy=1
//  s_we           in   1         1=write, 0=read
//  s_addr         in   32        byte address
//  s_byte         in   4         write byte enables
//  s_di           in   32        write data
//  s_do           out  32        read data, valid in the cycle s_busy falls after a read
//  s_busy         out  1         request in flight; core must hold request
//  s_err          out  1         response error, valid with s_do (same cycle)
//  m_awid/m_arid  out  ID_WIDTH  constant AXI_ID
//  m_awaddr       out  32        captured s_addr
//  m_araddr       out  32        captured s_addr
//  m_awlen/arlen  out  8         constant 0 (single beat)
//  m_awsize/arsize out 3         constant 3'b010 (4 bytes)
//  m_awburst/arburst out 2       constant 2'b01 (INCR)
//  m_awvalid      out  1         write address valid
//  m_awready      in   1         write address ready
//  m_wdata        out  32        captured s_di
//  m_wstrb        out  4         captured s_byte
//  m_wlast        out  1         constant 1
//  m_wvalid       out  1         write data valid
//  m_wready       in   1         write data ready
//  m_bid          in   ID_WIDTH  ignored
//  m_bresp        in   2         write response
//  m_bvalid       in   1         write response valid
//  m_bready       out  1         =1 only in state B
//  m_arvalid      out  1         read address valid
//  m_arready      in   1         read address ready
//  m_rid          in   ID_WIDTH  ignored
//  m_rdata        in   32        read data
//  m_rresp        in   2         read response
//  m_rlast        in   1         ignored (always single beat)
//  m_rvalid       in   1         read data valid
//  m_rready       out  1         =1 only in state R
// BEHAVIOUR
//  - Reset: state IDLE; all *valid, m_bready, m_rready, s_err = 0; s_do = 0; captured address/data/strobe registers = 0.
//  - FSM: IDLE, AR, R, AW_W, B, DONE.
//  - IDLE, s_cs=1: capture addr/di/byte; s_we=0 -> AR, s_we=1 -> AW_W.
//  - s_busy = (state in AR,R,AW_W,B) | (state==IDLE & s_cs); s_busy=0 in DONE.
//  - AR: m_arvalid=1 until m_arready; on handshake -> R. R: m_rready=1; on m_rvalid, register s_do=m_rdata and s_err=m_rresp[1], then -> DONE.
//  - AW_W: m_awvalid and m_wvalid rise together (registered, first cycle after capture).
//    Each drops independently on its own ready; handshakes may occur in either order or the same cycle.
//    -> B when both have completed.
//  - B: m_bready=1; on m_bvalid, s_err=m_bresp[1] -> DONE. s_do is not modified by writes.
//  - DONE: single cycle; s_busy=0 so the core samples s_do/s_err; always -> IDLE.
//    s_cs in DONE is the completed request and is not re-issued. s_err clears when the next request is captured.
//  - AXI rule: a valid once asserted stays high with stable payload until ready; payload regs change only in IDLE.
//  - Min latency: read busy for 3 cycles (capture, AR, R) with zero-wait slave; write likewise (capture, AW_W, B).
//  - Back-to-back: a new request is accepted earliest in the IDLE cycle after DONE.
//  - Reset mid-transaction: immediate return to IDLE, valids drop. The outstanding AXI transaction is abandoned;
//    the system resets the slave side together with this block.
// TESTING
//  - Read, zero-wait slave: s_cs=1,we=0,addr=0x1000, rdata=0xDEADBEEF, rresp=0 -> m_araddr=0x1000, arlen=0; s_busy high 3 cycles; s_do=0xDEADBEEF, s_err=0 when busy falls.
//  - Write, awready 2 cycles before wready: addr=0x2004, di=0x12345678, byte=4'b0110 -> wstrb=0110, wlast=1; valids held until each ready; B state entered only after both; s_busy falls the cycle after bvalid.
//  - Error: read with rresp=2'b10 -> s_err=1 with s_do=rdata; following write with bresp=0 -> s_err=0 and s_do unchanged.
//  - Backpressure: arready low 5 cycles, rvalid delayed 4 cycles -> m_arvalid/m_araddr stable throughout; s_busy held; no second AR issued.
//  - Back-to-back: core re-asserts cs with new addr right after DONE -> second AR issued one cycle after capture, no request duplicated or dropped.
//  - Reset asserted in B -> next edge: all valids/readies 0, state IDLE, s_busy=s_cs; a fresh read after reset completes normally.

Source files
------------

// File: rtl/mem2axi_bridge.sv
// Core-side memory request (cs/we/addr/byte/di) to single-beat AXI4 master bridge.
// One outstanding transaction; the read or write path is chosen when the request is captured.
module mem2axi_bridge #(
  parameter int          ID_WIDTH = 10,
  parameter int unsigned AXI_ID   = 0
) (
  input  logic                clk,
  input  logic                rst,
  // core side
  input  logic                s_cs,
  input  logic                s_we,
  input  logic [31:0]         s_addr,
  input  logic [3:0]          s_byte,
  input  logic [31:0]         s_di,
  output logic [31:0]         s_do,
  output logic                s_busy,
  output logic                s_err,
  // AXI write address
  output logic [ID_WIDTH-1:0] m_awid,
  output logic [31:0]         m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_awvalid,
  input  logic                m_awready,
  // AXI write data
  output logic [31:0]         m_wdata,
  output logic [3:0]          m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  // AXI write response
  input  logic [ID_WIDTH-1:0] m_bid,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  // AXI read address
  output logic [ID_WIDTH-1:0] m_arid,
  output logic [31:0]         m_araddr,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  output logic                m_arvalid,
  input  logic                m_arready,
  // AXI read data
  input  logic [ID_WIDTH-1:0] m_rid,
  input  logic [31:0]         m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready,
  // debug
  output logic [2:0]          dbg_state_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AW_W = 3'd3;
  localparam logic [2:0] S_B    = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  // Handshake rule on every AXI channel: a transfer happens on a rising clk edge where
  // valid and ready are both high; once valid rises it and its payload stay put until then.

  logic [2:0]  state_q,   state_d;
  logic [31:0] addr_q,    addr_d;
  logic [31:0] data_q,    data_d;
  logic [3:0]  strb_q,    strb_d;
  logic [31:0] do_q,      do_d;
  logic        err_q,     err_d;
  logic        arvalid_q, arvalid_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q,  wvalid_d;

  // Response IDs, rlast and the low response bit carry no information for single-beat use.
  logic unused_inputs;
  assign unused_inputs = ^{m_bid, m_rid, m_rlast, m_bresp[0], m_rresp[0]};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    do_d      = do_q;
    err_d     = err_q;
    arvalid_d = arvalid_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    case (state_q)
      S_IDLE: begin
        if (s_cs) begin
          addr_d = s_addr;
          data_d = s_di;
          strb_d = s_byte;
          err_d  = 1'b0;
          if (s_we) begin
            state_d   = S_AW_W;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_AR: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          state_d   = S_R;
        end
      end
      S_R: begin
        if (m_rvalid) begin
          do_d    = m_rdata;
          err_d   = m_rresp[1];
          state_d = S_DONE;
        end
      end
      S_AW_W: begin
        // Address and data channels complete independently, in either order.
        if (m_awready) awvalid_d = 1'b0;
        if (m_wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = S_B;
      end
      S_B: begin
        if (m_bvalid) begin
          err_d   = m_bresp[1];
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      do_q      <= '0;
      err_q     <= 1'b0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      do_q      <= do_d;
      err_q     <= err_d;
      arvalid_q <= arvalid_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
    end
  end

  // Busy covers the capture cycle too, so the core holds its request until DONE.
  assign s_busy = (state_q == S_AR) || (state_q == S_R) || (state_q == S_AW_W) ||
                  (state_q == S_B)  || ((state_q == S_IDLE) && s_cs);
  assign s_do   = do_q;
  assign s_err  = err_q;

  assign m_awid    = ID_WIDTH'(AXI_ID);
  assign m_arid    = ID_WIDTH'(AXI_ID);
  assign m_awaddr  = addr_q;
  assign m_araddr  = addr_q;
  assign m_awlen   = 8'd0;
  assign m_arlen   = 8'd0;
  assign m_awsize  = 3'b010;
  assign m_arsize  = 3'b010;
  assign m_awburst = 2'b01;
  assign m_arburst = 2'b01;
  assign m_awvalid = awvalid_q;
  assign m_wvalid  = wvalid_q;
  assign m_arvalid = arvalid_q;
  assign m_wdata   = data_q;
  assign m_wstrb   = strb_q;
  assign m_wlast   = 1'b1;
  assign m_bready  = (state_q == S_B);
  assign m_rready  = (state_q == S_R);

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem2axi_bridge.sv
// Directed bench for mem2axi_bridge: slave responses are driven by hand step by step.
module tb_mem2axi_bridge;
  localparam int IDW = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic           s_cs, s_we;
  logic [31:0]    s_addr, s_di, s_do;
  logic [3:0]     s_byte;
  logic           s_busy, s_err;
  logic [IDW-1:0] m_awid, m_arid, m_bid, m_rid;
  logic [31:0]    m_awaddr, m_araddr, m_wdata, m_rdata;
  logic [7:0]     m_awlen, m_arlen;
  logic [2:0]     m_awsize, m_arsize, dbg_state;
  logic [1:0]     m_awburst, m_arburst, m_bresp, m_rresp;
  logic           m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
  logic           m_bvalid, m_bready, m_arvalid, m_arready;
  logic           m_rlast, m_rvalid, m_rready;
  logic [3:0]     m_wstrb;

  int n_cmp = 0;
  int n_err = 0;
  int ar_cnt = 0;
  int aw_cnt = 0;

  mem2axi_bridge #(.ID_WIDTH(IDW), .AXI_ID(0)) dut (
    .clk(clk), .rst(rst),
    .s_cs(s_cs), .s_we(s_we), .s_addr(s_addr), .s_byte(s_byte), .s_di(s_di),
    .s_do(s_do), .s_busy(s_busy), .s_err(s_err),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_arvalid && m_arready) ar_cnt++;
    if (m_awvalid && m_awready) aw_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] di,
                     input logic [3:0] be);
    s_cs = 1'b1; s_we = we; s_addr = addr; s_di = di; s_byte = be;
  endtask

  initial begin
    rst = 1'b1;
    s_cs = 0; s_we = 0; s_addr = 0; s_di = 0; s_byte = 0;
    m_awready = 0; m_wready = 0; m_bid = '0; m_bresp = 0; m_bvalid = 0;
    m_arready = 0; m_rid = '0; m_rdata = 0; m_rresp = 0; m_rlast = 1; m_rvalid = 0;
    step(); step();

    // reset state and constant fields
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_valids", {29'd0, m_arvalid, m_awvalid, m_wvalid}, 32'd0);
    chk("rst_readies", {30'd0, m_bready, m_rready}, 32'd0);
    chk("rst_do", s_do, 32'd0);
    chk("rst_err", 32'(s_err), 32'd0);
    chk("rst_regs", m_awaddr | m_wdata | 32'(m_wstrb), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("const_len", {m_awlen, m_arlen}, 32'd0);
    chk("const_size_burst", {m_awsize, m_arsize, m_awburst, m_arburst}, 32'b010_010_01_01);
    chk("const_wlast_id", {m_wlast, 10'(m_awid), 10'(m_arid)}, 32'h100000);
    rst = 1'b0;

    // read, zero-wait slave
    req(0, 32'h1000, 0, 0);
    m_arready = 1; m_rvalid = 1; m_rdata = 32'hDEADBEEF; m_rresp = 0;
    #1 chk("rd_busy_c0", 32'(s_busy), 32'd1);
    step();
    chk("rd_ar_state", {29'(dbg_state), s_busy, m_arvalid, m_rready}, {29'd1, 3'b110});
    chk("rd_araddr", m_araddr, 32'h1000);
    step();
    chk("rd_r_state", {29'(dbg_state), s_busy, m_arvalid, m_rready}, {29'd2, 3'b101});
    step();
    chk("rd_done_busy", 32'(s_busy), 32'd0);
    chk("rd_do", s_do, 32'hDEADBEEF);
    chk("rd_err", 32'(s_err), 32'd0);
    s_cs = 0; m_arready = 0; m_rvalid = 0;
    step();
    chk("rd_idle", 32'(dbg_state), 32'd0);

    // write, awready two cycles ahead of wready
    req(1, 32'h2004, 32'h12345678, 4'b0110);
    #1 chk("wr_busy_c0", 32'(s_busy), 32'd1);
    step();
    chk("wr_valids_rise", {29'(dbg_state), m_awvalid, m_wvalid, s_busy}, {29'd3, 3'b111});
    chk("wr_awaddr", m_awaddr, 32'h2004);
    chk("wr_wdata", m_wdata, 32'h12345678);
    chk("wr_wstrb_wlast", {m_wstrb, m_wlast}, 32'b0110_1);
    m_awready = 1;
    step();
    chk("wr_aw_done", {29'(dbg_state), m_awvalid, m_wvalid, m_bready}, {29'd3, 3'b010});
    m_awready = 0;
    step();
    chk("wr_w_held", {29'(dbg_state), m_awvalid, m_wvalid, m_bready}, {29'd3, 3'b010});
    chk("wr_wdata_stable", m_wdata, 32'h12345678);
    m_wready = 1;
    step();
    chk("wr_b_entered", {29'(dbg_state), m_awvalid, m_wvalid, m_bready}, {29'd4, 3'b001});
    m_wready = 0;
    step();
    chk("wr_b_wait", {30'(dbg_state), s_busy, m_bready}, {30'd4, 2'b11});
    m_bvalid = 1; m_bresp = 0;
    step();
    chk("wr_done", {30'(dbg_state), s_busy, s_err}, {30'd5, 2'b00});
    chk("wr_do_kept", s_do, 32'hDEADBEEF);
    s_cs = 0; m_bvalid = 0;
    step();

    // read error, then clean write
    req(0, 32'h1010, 0, 0);
    m_arready = 1; m_rvalid = 1; m_rdata = 32'hCAFEF00D; m_rresp = 2'b10;
    step(); step(); step();
    chk("err_rd_do", s_do, 32'hCAFEF00D);
    chk("err_rd_err", {30'(dbg_state), s_busy, s_err}, {30'd5, 2'b01});
    s_cs = 0; m_arready = 0; m_rvalid = 0; m_rresp = 0;
    step();
    chk("err_held_idle", 32'(s_err), 32'd1);
    req(1, 32'h2008, 32'hA5A5A5A5, 4'b1111);
    m_awready = 1; m_wready = 1; m_bvalid = 1; m_bresp = 0;
    step();
    chk("err_clr_on_capture", {30'(dbg_state), s_err}, {30'd3, 1'b0});
    step(); step();
    chk("err_wr_done", {30'(dbg_state), s_busy, s_err}, {30'd5, 2'b00});
    chk("err_wr_do_kept", s_do, 32'hCAFEF00D);
    s_cs = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
    step();

    // backpressure: arready low 5 cycles, rvalid 4 cycles late
    req(0, 32'h3008, 0, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_ar_hold", {29'(dbg_state), m_arvalid, s_busy, m_rready}, {29'd1, 3'b110});
      chk("bp_araddr", m_araddr, 32'h3008);
      step();
    end
    m_arready = 1;
    step();
    m_arready = 0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_r_wait", {29'(dbg_state), m_arvalid, s_busy, m_rready}, {29'd2, 3'b011});
      step();
    end
    m_rvalid = 1; m_rdata = 32'h0BADC0DE; m_rresp = 0;
    step();
    chk("bp_done", {30'(dbg_state), s_busy, s_err}, {30'd5, 2'b00});
    chk("bp_do", s_do, 32'h0BADC0DE);
    s_cs = 0; m_rvalid = 0;
    step();

    // back-to-back reads
    req(0, 32'h4000, 0, 0);
    m_arready = 1; m_rvalid = 1; m_rdata = 32'h11111111;
    step(); step(); step();
    chk("b2b_first_do", s_do, 32'h11111111);
    req(0, 32'h5000, 0, 0);
    m_rdata = 32'h22222222;
    #1 chk("b2b_done_not_busy", {30'(dbg_state), s_busy, m_arvalid}, {30'd5, 2'b00});
    step();
    chk("b2b_capture", {30'(dbg_state), s_busy, m_arvalid}, {30'd0, 2'b10});
    step();
    chk("b2b_second_ar", {30'(dbg_state), m_arvalid, s_busy}, {30'd1, 2'b11});
    chk("b2b_araddr", m_araddr, 32'h5000);
    step(); step();
    chk("b2b_second_do", {29'(dbg_state), s_busy}, {29'd5, 1'b0});
    chk("b2b_second_data", s_do, 32'h22222222);
    s_cs = 0; m_arready = 0; m_rvalid = 0;
    step();

    // reset while waiting in B, then a fresh read
    req(1, 32'h6000, 32'h66666666, 4'b1111);
    m_awready = 1; m_wready = 1;
    step(); step();
    chk("rstb_in_b", {30'(dbg_state), m_bready, s_busy}, {30'd4, 2'b11});
    m_awready = 0; m_wready = 0;
    rst = 1'b1;
    #1;
    chk("rstb_state", 32'(dbg_state), 32'd0);
    chk("rstb_handshakes", {27'd0, m_arvalid, m_awvalid, m_wvalid, m_bready, m_rready}, 32'd0);
    chk("rstb_busy_eq_cs", 32'(s_busy), 32'(s_cs));
    step();
    s_cs = 0;
    rst = 1'b0;
    #1 chk("rstb_do_cleared", s_do, 32'd0);
    req(0, 32'h7000, 0, 0);
    m_arready = 1; m_rvalid = 1; m_rdata = 32'h77777777; m_rresp = 0;
    step();
    chk("rstb_fresh_araddr", m_araddr, 32'h7000);
    step(); step();
    chk("rstb_fresh_done", {30'(dbg_state), s_busy, s_err}, {30'd5, 2'b00});
    chk("rstb_fresh_do", s_do, 32'h77777777);
    s_cs = 0; m_arready = 0; m_rvalid = 0;
    step();

    // no request duplicated or dropped across the whole run
    chk("total_ar", 32'(ar_cnt), 32'd6);
    chk("total_aw", 32'(aw_cnt), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time budget");
    $fatal(1, "timeout");
  end
endmodule
